// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Produces difference, unsigned borrow and signed overflow with fixed latency.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             N_RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] sa, sb, res, rnext;
  logic [CW-1:0]    cnt;
  logic             br, ma, mb;
  logic             dbit, brn, last;

  assign dbit  = sa[0] ^ sb[0] ^ br;
  assign brn   = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
  assign rnext = {dbit, res[WIDTH-1:1]};
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt  = state;
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state)
      IDLE: if (START) nxt = RUN;
      RUN: begin
        BUSY = 1'b1;
        if (last) nxt = FIN;
      end
      FIN: begin
        DONE = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      ma   <= 1'b0;
      mb   <= 1'b0;
      D    <= '0;
      BOUT <= 1'b0;
      OVF  <= 1'b0;
    end else if (state == IDLE && START) begin
      sa  <= A;
      sb  <= B;
      ma  <= A[WIDTH-1];
      mb  <= B[WIDTH-1];
      res <= '0;
      cnt <= '0;
      br  <= 1'b0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= rnext;
      br  <= brn;
      cnt <= cnt + CW'(1);
      // last bit: publish the completed result on the FIN-entry edge
      if (last) begin
        D    <= rnext;
        BOUT <= brn;
        OVF  <= (ma ^ mb) & (ma ^ dbit);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): vector table,
// scoreboard queue, back-to-back, mid-run reset and hold checks.
module tb_serial_sub;

  localparam int W = 8;

  logic         CLK, N_RESET, START;
  logic [W-1:0] A, B, D;
  logic         BOUT, OVF, BUSY, DONE;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  logic [W+1:0] sb_q[$];
  logic [W-1:0] last_d;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t tbl[8];

  serial_sub #(.WIDTH(W)) dut (
    .CLK(CLK), .N_RESET(N_RESET), .START(START),
    .A(A), .B(B), .D(D), .BOUT(BOUT), .OVF(OVF),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] d;
    logic bo, ov;
    d  = a - b;
    bo = (a < b);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {d, bo, ov};
  endfunction

  // scoreboard + hold monitor
  always @(negedge CLK) begin
    if (N_RESET) begin
      if (DONE) begin
        n_done++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("result", {22'd0, D, BOUT, OVF}, {22'd0, sb_q.pop_front()});
        end
      end
      if (BUSY) chk("hold_d", {24'd0, D}, {24'd0, last_d});
    end
    last_d = D;
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W+1:0] exp);
    int nb;
    bit seen;
    nb = 0;
    seen = 0;
    @(negedge CLK);
    A = a;
    B = b;
    START = 1'b1;
    sb_q.push_back(exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      START = 1'b0;
      A = W'($urandom);
      B = W'($urandom);
      if (DONE) begin
        seen = 1;
        break;
      end
      if (BUSY) nb++;
    end
    chk("done_seen", 32'(seen), 1);
    chk("busy_cycles", nb, W);
    @(negedge CLK);
    chk("done_pulse_1cyc", {31'd0, DONE}, 0);
  endtask

  initial begin
    tbl[0] = '{8'h5A, 8'h21, 8'h39, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
    tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

    N_RESET = 1'b0;
    START = 1'b0;
    A = '0;
    B = '0;
    #1;
    chk("reset_outs", {27'd0, D, BOUT, OVF, BUSY, DONE}, 0);
    repeat (2) @(negedge CLK);
    N_RESET = 1'b1;

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, {tbl[i].d, tbl[i].bout, tbl[i].ovf});

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, model(ra, rb));
    end

    // START held high, operands changing every cycle
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      A = W'($urandom);
      B = W'($urandom);
      START = (i != 29);
      if (i % 10 == 0) sb_q.push_back(model(A, B));
    end
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge CLK);
    chk("b2b_drained", sb_q.size(), 0);
    chk("b2b_ops", n_done, 3);

    // reset four cycles into RUN
    @(negedge CLK);
    A = 8'h10;
    B = 8'h03;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre_reset_busy", {31'd0, BUSY}, 1);
    #2;
    N_RESET = 1'b0;
    #1;
    chk("midrun_reset", {27'd0, D, BOUT, OVF, BUSY, DONE}, 0);
    n_done = 0;
    repeat (12) begin
      @(posedge CLK);
      #1;
      chk("reset_no_done", {31'd0, DONE}, 0);
    end
    @(negedge CLK);
    N_RESET = 1'b1;
    run_op(8'h5A, 8'h21, model(8'h5A, 8'h21));
    run_op(8'h33, 8'h44, model(8'h33, 8'h44));
    chk("final_q", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH SHALL be an operand width in bits, default 8, legal range 2..32.
REQ-002 Port CLK SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port N_RESET SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port START SHALL be an input, 1 bit: request to begin a subtraction.
REQ-005 Port A SHALL be an input, WIDTH bits: minuend, sampled with START.
REQ-006 Port B SHALL be an input, WIDTH bits: subtrahend, sampled with START.
REQ-007 Port D SHALL be an output, WIDTH bits: registered difference A-B modulo 2^WIDTH.
REQ-008 Port BOUT SHALL be an output, 1 bit: final borrow, 1 when unsigned A<B.
REQ-009 Port OVF SHALL be an output, 1 bit: signed two's-complement overflow of A-B.
REQ-010 Port BUSY SHALL be an output, 1 bit: high while bits are being processed.
REQ-011 Port DONE SHALL be an output, 1 bit: one-cycle pulse marking D/BOUT/OVF valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and FIN.
REQ-013 In IDLE, START=1 at a rising edge SHALL load A and B into internal shift registers, clear the borrow flop, clear the bit counter and enter RUN.
REQ-014 In RUN, each edge SHALL process one bit, LSB first: diff = a^b^br; br_next = (~a&b) | (~a&br) | (b&br); operands shift right; diff shifts into the result register from the MSB end.
REQ-015 The bit counter SHALL be wide enough to count WIDTH and SHALL increment once per RUN edge.
REQ-016 On the edge that processes bit WIDTH-1, the FSM SHALL enter FIN and update D, BOUT and OVF with the completed result in the same edge.
REQ-017 OVF SHALL equal (A[MSB]^B[MSB]) & (A[MSB]^D[MSB]), using the captured operands.
REQ-018 FIN SHALL last exactly one cycle, with DONE=1, then return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: with START sampled at edge k, DONE is high from edge k+WIDTH to edge k+WIDTH+1.
REQ-020 BUSY SHALL be 1 exactly while the state is RUN (WIDTH cycles) and 0 otherwise.
REQ-021 START SHALL be ignored in RUN and FIN, with no effect on operands, counter or outputs.
REQ-022 D, BOUT and OVF SHALL hold their last completed values during IDLE and RUN, and change only on the FIN-entry edge.
REQ-023 Back-to-back operation SHALL work: START=1 in the first IDLE cycle after FIN begins a new operation, so the minimum issue interval is WIDTH+2 cycles.
REQ-024 Changes on A and B outside the START-sampling edge SHALL NOT affect the operation in progress.

Reset
REQ-025 N_RESET=0 SHALL immediately, without waiting for a clock edge, force IDLE and clear D, BOUT, OVF, BUSY, DONE, the borrow flop, the counter and the shift registers.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse and no partial result visible on D.
REQ-027 After N_RESET deasserts, the first rising edge with START=1 SHALL begin an operation normally.

Verification (WIDTH=8)
REQ-028 Basic subtraction: A=0x5A, B=0x21, START for 1 cycle -> BUSY high for 8 cycles; DONE pulses at edge k+8; D=0x39, BOUT=0, OVF=0.
REQ-029 Unsigned underflow: A=0x00, B=0x01 -> D=0xFF, BOUT=1, OVF=0; A=0x80, B=0x01 -> D=0x7F, BOUT=0, OVF=1.
REQ-030 Equal operands and wrap: A=0x80, B=0x80 -> D=0x00, BOUT=0, OVF=0; A=0x7F, B=0xFF -> D=0x80, BOUT=1, OVF=1.
REQ-031 START held high continuously with A and B changed every cycle -> one operation per 10 cycles; each result matches the operands sampled at that operation's starting edge.
REQ-032 Reset mid-operation: N_RESET=0 at cycle 4 of RUN -> all outputs 0 immediately with no DONE; a new START after release yields a correct result.
REQ-033 Hold check: a new START with different operands -> D keeps the previous result throughout RUN and changes only when DONE is asserted.
